// File: rtl/styler_pkg.sv
// styler_pkg: shared definitions for the styler pixel path.
//   CELL_WIDTH : default character-cell row width in pixels (16)
//   COLOR_W    : width of a colour index (4)
//   cell_t     : one styled row as it travels hold -> active
//                {bitmap, last[, fg, bg]}
// Colour fields exist only when STYLER_SHIFTER_COLOR_EN is defined.
package styler_pkg;

  localparam int CELL_WIDTH = 16;
  localparam int COLOR_W    = 4;

  typedef struct packed {
    logic [CELL_WIDTH-1:0] bitmap;
    logic                  last;
`ifdef STYLER_SHIFTER_COLOR_EN
    logic [COLOR_W-1:0]    fg;
    logic [COLOR_W-1:0]    bg;
`endif
  } cell_t;

endpackage

// File: rtl/styler_shifter_hold.sv
// styler_shifter_hold: one-entry holding register in front of the shifter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : upstream valid
//   ready       : entry is free (~holdValid); depends only on state
//   cellIn      : row offered by upstream
//   pop         : downstream takes the entry this cycle
//   holdValid   : entry is occupied
//   cellOut     : stored row
// Handshake: a row is taken on a cycle where push & ready are both high;
// push must hold cellIn stable until then. push and pop can never both
// act in one cycle because pop needs holdValid=1 and push needs ready=1.
module styler_shifter_hold
  import styler_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  output logic  ready,
  input  cell_t cellIn,
  input  logic  pop,
  output logic  holdValid,
  output cell_t cellOut
);

  assign ready = ~holdValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdValid <= 1'b0;
      cellOut   <= '0;
    end else if (push && ready) begin
      holdValid <= 1'b1;
      cellOut   <= cellIn;
    end else if (pop) begin
      holdValid <= 1'b0;
    end
  end

endmodule

// File: rtl/styler_shifter.sv
// styler_shifter: pixel serializer behind the combinational styler.
// Takes one styled row per valid/ready transfer into a hold register, moves
// it into an active shift register and emits one pixel per pix_en cycle.
// The hold register lets the next row load on the same enable that
// consumes the final pixel, so output is gap-free across cells.
// Optional feature macro: STYLER_SHIFTER_COLOR_EN adds in_fg/in_bg and
// pix_fg/pix_bg; colour indices travel with the row.
// Parameters:
//   WIDTH     : pixels per row, power of two in 2..16
//   MSB_FIRST : 1 emits bitmap[WIDTH-1] first, 0 emits bitmap[0] first
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : row handshake; a row is taken when both are high,
//                          and in_valid holds the row stable until then.
//                          in_ready = ~hold_valid (no path from pix_en)
//   in_bitmap, in_last   : row pixels, row ends the current line
//   in_fg, in_bg         : colour indices (colour builds)
//   pix_en               : pixel-rate enable
//   pix_out, pix_valid   : current pixel (0 when invalid), pixel present
//   pix_fg, pix_bg       : current colours, 0 when invalid (colour builds)
//   pix_eol              : current pixel is the last of an in_last row
//   underrun, clr_underrun : sticky mid-line starvation flag and its clear
module styler_shifter
  import styler_pkg::*;
#(
  parameter int WIDTH     = CELL_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_bitmap,
  input  logic               in_last,
`ifdef STYLER_SHIFTER_COLOR_EN
  input  logic [COLOR_W-1:0] in_fg,
  input  logic [COLOR_W-1:0] in_bg,
  output logic [COLOR_W-1:0] pix_fg,
  output logic [COLOR_W-1:0] pix_bg,
`endif
  input  logic               pix_en,
  output logic               pix_out,
  output logic               pix_valid,
  output logic               pix_eol,
  output logic               underrun,
  input  logic               clr_underrun
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  cell_t            cellIn;
  cell_t            holdCell;
  logic             holdValid;
  logic             holdReady;

  logic [WIDTH-1:0] shiftReg;
  logic [WIDTH-1:0] shiftNext;
  logic [CNT_W-1:0] cnt;
  logic             actValid;
  logic             actLast;
  logic             atLast;
  logic             xfer;
  logic             outBit;
  logic             lineActive;
`ifdef STYLER_SHIFTER_COLOR_EN
  logic [COLOR_W-1:0] actFg;
  logic [COLOR_W-1:0] actBg;
`endif

  // Rows narrower than CELL_WIDTH sit in the low bits of the cell.
  always_comb begin
    cellIn                    = '0;
    cellIn.bitmap[WIDTH-1:0]  = in_bitmap;
    cellIn.last               = in_last;
`ifdef STYLER_SHIFTER_COLOR_EN
    cellIn.fg                 = in_fg;
    cellIn.bg                 = in_bg;
`endif
  end

  styler_shifter_hold u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .ready     (holdReady),
    .cellIn    (cellIn),
    .pop       (xfer),
    .holdValid (holdValid),
    .cellOut   (holdCell)
  );

  assign in_ready = holdReady;

  assign atLast = (cnt == LAST_CNT);
  // Load when active is empty, or on the enable that consumes its final
  // pixel so the next row's first pixel follows with no bubble.
  assign xfer   = holdValid & (~actValid | (pix_en & atLast));

  always_comb begin
    if (MSB_FIRST) begin
      shiftNext = {shiftReg[WIDTH-2:0], 1'b0};
      outBit    = shiftReg[WIDTH-1];
    end else begin
      shiftNext = {1'b0, shiftReg[WIDTH-1:1]};
      outBit    = shiftReg[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg <= '0;
      cnt      <= '0;
      actValid <= 1'b0;
      actLast  <= 1'b0;
`ifdef STYLER_SHIFTER_COLOR_EN
      actFg    <= '0;
      actBg    <= '0;
`endif
    end else if (xfer) begin
      shiftReg <= holdCell.bitmap[WIDTH-1:0];
      cnt      <= '0;
      actValid <= 1'b1;
      actLast  <= holdCell.last;
`ifdef STYLER_SHIFTER_COLOR_EN
      actFg    <= holdCell.fg;
      actBg    <= holdCell.bg;
`endif
    end else if (actValid && pix_en) begin
      if (atLast) begin
        actValid <= 1'b0;
      end else begin
        shiftReg <= shiftNext;
        cnt      <= cnt + 1'b1;
      end
    end
  end

  assign pix_valid = actValid;
  assign pix_out   = actValid & outBit;
  assign pix_eol   = actValid & actLast & atLast;
`ifdef STYLER_SHIFTER_COLOR_EN
  assign pix_fg    = actValid ? actFg : '0;
  assign pix_bg    = actValid ? actBg : '0;
`endif

  // A line is in progress from its first row load until its EOL pixel is
  // consumed; a load in that same cycle starts the next line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lineActive <= 1'b0;
    end else if (xfer) begin
      lineActive <= 1'b1;
    end else if (pix_eol && pix_en) begin
      lineActive <= 1'b0;
    end
  end

  // Starvation inside a line is an error; enables between lines are
  // blanking. A new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (pix_en && lineActive && !actValid) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_styler_shifter.sv
// Bench for styler_shifter: one MSB-first instance carries most scenarios,
// a second LSB-first instance carries the bit-order case. Expected pixels
// are queued when a row is accepted and popped by monitors whenever the
// DUT consumes a pixel (pix_valid & pix_en).
module tb_styler_shifter;

  logic clk;
  logic rst_n;
  logic pix_en;
  int   enMode;  // 0: off, 1: always on, 2: toggle every cycle

  logic        mValid, mReady, mLast, mOut, mPixValid, mEol, mUnder, mClr;
  logic [15:0] mBitmap;
  logic [3:0]  mFg, mBg, mPixFg, mPixBg;

  logic        lValid, lReady, lLast, lOut, lPixValid, lEol, lUnder;
  logic [15:0] lBitmap;
  logic [3:0]  lFg, lBg, lPixFg, lPixBg;

  int checks;
  int errors;
  int runLen;
  int lastRun;

  logic [9:0] exp_q[$];
  logic [9:0] expL_q[$];

  styler_shifter #(.WIDTH(16), .MSB_FIRST(1'b1)) dutM (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (mValid),
    .in_ready     (mReady),
    .in_bitmap    (mBitmap),
    .in_last      (mLast),
`ifdef STYLER_SHIFTER_COLOR_EN
    .in_fg        (mFg),
    .in_bg        (mBg),
    .pix_fg       (mPixFg),
    .pix_bg       (mPixBg),
`endif
    .pix_en       (pix_en),
    .pix_out      (mOut),
    .pix_valid    (mPixValid),
    .pix_eol      (mEol),
    .underrun     (mUnder),
    .clr_underrun (mClr)
  );

  styler_shifter #(.WIDTH(16), .MSB_FIRST(1'b0)) dutL (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (lValid),
    .in_ready     (lReady),
    .in_bitmap    (lBitmap),
    .in_last      (lLast),
`ifdef STYLER_SHIFTER_COLOR_EN
    .in_fg        (lFg),
    .in_bg        (lBg),
    .pix_fg       (lPixFg),
    .pix_bg       (lPixBg),
`endif
    .pix_en       (pix_en),
    .pix_out      (lOut),
    .pix_valid    (lPixValid),
    .pix_eol      (lEol),
    .underrun     (lUnder),
    .clr_underrun (1'b0)
  );

`ifndef STYLER_SHIFTER_COLOR_EN
  assign mPixFg = 4'h0;
  assign mPixBg = 4'h0;
  assign lPixFg = 4'h0;
  assign lPixBg = 4'h0;
`endif

  // ---------------- clock / reset / enable ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pix_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (enMode)
        1:       pix_en = 1'b1;
        2:       pix_en = ~pix_en;
        default: pix_en = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (mPixValid && pix_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_m: pixel consumed with nothing expected, got %0b", mOut);
        end else begin
          e = exp_q.pop_front();
          check("mon_m pixel{out,eol,fg,bg}", {22'd0, mOut, mEol, mPixFg, mPixBg}, {22'd0, e});
        end
      end else if (!mPixValid) begin
        check("mon_m idle{out,eol,fg,bg}", {22'd0, mOut, mEol, mPixFg, mPixBg}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && lPixValid && pix_en) begin
      if (expL_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_l: pixel consumed with nothing expected, got %0b", lOut);
      end else begin
        e = expL_q.pop_front();
        check("mon_l pixel{out,eol,fg,bg}", {22'd0, lOut, lEol, lPixFg, lPixBg}, {22'd0, e});
      end
    end
  end

  // Length of the most recent contiguous pix_valid run on dutM.
  always @(negedge clk) begin
    if (!rst_n) begin
      runLen <= 0;
    end else if (mPixValid) begin
      runLen <= runLen + 1;
    end else if (runLen != 0) begin
      lastRun <= runLen;
      runLen  <= 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_row(input bit toL, input logic [15:0] bm, input logic last,
                          input logic [3:0] fg, input logic [3:0] bg);
    bit         accepted;
    logic       rdy;
    logic       b;
    logic [3:0] fgE;
    logic [3:0] bgE;
    accepted = 1'b0;
    if (toL) begin
      lValid = 1'b1; lBitmap = bm; lLast = last; lFg = fg; lBg = bg;
    end else begin
      mValid = 1'b1; mBitmap = bm; mLast = last; mFg = fg; mBg = bg;
    end
    for (int k = 0; k < 100; k++) begin
      rdy = toL ? lReady : mReady;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    mValid = 1'b0;
    lValid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_row: in_ready never rose, got 0, expected 1");
    end else begin
`ifdef STYLER_SHIFTER_COLOR_EN
      fgE = fg;
      bgE = bg;
`else
      fgE = 4'h0;
      bgE = 4'h0;
`endif
      for (int i = 0; i < 16; i++) begin
        b = toL ? bm[i] : bm[15-i];
        if (toL) expL_q.push_back({b, last && (i == 15), fgE, bgE});
        else     exp_q.push_back({b, last && (i == 15), fgE, bgE});
      end
    end
  endtask

  // Wait for dutM to start and then finish emitting, bounded.
  task automatic wait_idle(input string name);
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mPixValid) seen = 1'b1;
      else if (seen) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: output did not drain, got busy, expected idle", name);
    end
    @(negedge clk);
  endtask

  task automatic to_posedge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    checks = 0; errors = 0; enMode = 0; lastRun = 0;
    mValid = 0; mBitmap = '0; mLast = 0; mFg = 0; mBg = 0; mClr = 0;
    lValid = 0; lBitmap = '0; lLast = 0; lFg = 0; lBg = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {31'd0, mReady}, 32'd1);
    check("reset pix_valid", {31'd0, mPixValid}, 32'd0);
    check("reset pix_out/eol", {30'd0, mOut, mEol}, 32'd0);
    check("reset underrun", {31'd0, mUnder}, 32'd0);
    to_posedge();
    rst_n = 1'b1;

    // Single row, latency and run length.
    enMode = 1;
    to_posedge();
    send_row(0, 16'hA5C3, 1'b1, 4'h5, 4'hA);
    @(negedge clk);
    check("single latency N+1 pix_valid", {31'd0, mPixValid}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mPixValid) cnt++;
    end
    check("single valid cycles", cnt, 32'd16);
    @(negedge clk);
    check("single valid after row", {31'd0, mPixValid}, 32'd0);
    repeat (4) @(negedge clk);
    check("blanking after eol underrun", {31'd0, mUnder}, 32'd0);
    check("single queue drained", exp_q.size(), 32'd0);

    // Back-to-back rows, contiguous output.
    to_posedge();
    send_row(0, 16'hFFFF, 1'b0, 4'h1, 4'h2);
    send_row(0, 16'h0000, 1'b1, 4'h7, 4'h8);
    wait_idle("b2b");
    check("b2b contiguous run", lastRun, 32'd32);
    repeat (3) @(negedge clk);
    check("b2b line closed underrun", {31'd0, mUnder}, 32'd0);
    check("b2b queue drained", exp_q.size(), 32'd0);

    // Toggling enable, three rows.
    enMode = 2;
    to_posedge();
    send_row(0, 16'h8001, 1'b0, 4'h3, 4'h4);
    send_row(0, 16'h3C3C, 1'b0, 4'h9, 4'hB);
    @(negedge clk);
    check("toggle full in_ready", {31'd0, mReady}, 32'd0);
    to_posedge();
    send_row(0, 16'hF00F, 1'b1, 4'hE, 4'hD);
    wait_idle("toggle");
    check("toggle run 95..96", {31'd0, (lastRun == 95) || (lastRun == 96)}, 32'd1);
    check("toggle queue drained", exp_q.size(), 32'd0);

    // Underrun mid-line, sticky, set wins over clear.
    enMode = 1;
    repeat (3) to_posedge();
    send_row(0, 16'hFFFF, 1'b0, 4'h1, 4'h1);
    @(negedge clk);
    repeat (16) @(negedge clk);
    @(negedge clk);
    check("underrun not yet", {31'd0, mUnder}, 32'd0);
    @(negedge clk);
    check("underrun set", {31'd0, mUnder}, 32'd1);
    to_posedge();
    mClr = 1'b1;
    to_posedge();
    mClr = 1'b0;
    @(negedge clk);
    check("underrun set beats clear", {31'd0, mUnder}, 32'd1);
    to_posedge();
    send_row(0, 16'h00FF, 1'b1, 4'h2, 4'h6);
    wait_idle("underrun close");
    to_posedge();
    mClr = 1'b1;
    to_posedge();
    mClr = 1'b0;
    @(negedge clk);
    check("underrun cleared", {31'd0, mUnder}, 32'd0);
    repeat (5) @(negedge clk);
    check("idle pix_en no underrun", {31'd0, mUnder}, 32'd0);

    // Reset mid-cell.
    to_posedge();
    send_row(0, 16'hA5C3, 1'b1, 4'h5, 4'h5);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async reset pix_valid", {31'd0, mPixValid}, 32'd0);
    check("async reset pix_out/eol", {30'd0, mOut, mEol}, 32'd0);
    check("async reset in_ready", {31'd0, mReady}, 32'd1);
    to_posedge();
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset in_ready", {31'd0, mReady}, 32'd1);
    check("post reset pix_valid", {31'd0, mPixValid}, 32'd0);
    to_posedge();
    send_row(0, 16'h8000, 1'b1, 4'h0, 4'hF);
    wait_idle("post reset");
    check("post reset run", lastRun, 32'd16);
    check("post reset queue drained", exp_q.size(), 32'd0);

    // LSB-first instance with colours.
    to_posedge();
    send_row(1, 16'h0001, 1'b1, 4'h3, 4'hC);
    repeat (25) @(negedge clk);
    check("lsb queue drained", expL_q.size(), 32'd0);
    check("lsb underrun", {31'd0, lUnder}, 32'd0);
    check("msb underrun final", {31'd0, mUnder}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/styler_shifter.md
# styler_shifter

Pixel serializer directly downstream of the combinational styler. Accepts one styled 16-bit character-cell row per transfer over a valid/ready handshake and shifts it out one pixel per pixel-clock enable. A holding register behind the active shift register gives gap-free output across cells. The block also flags end-of-line and sticky underrun to the video timing logic.

## Interface
Parameters:
- WIDTH, 16, pixels per cell row; must be a power of two, 2..16.
- MSB_FIRST, 1, 1 shifts bit WIDTH-1 first (leftmost pixel); 0 shifts bit 0 first.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  block can accept a row; equals ~hold_valid, so there is no combinational path from pix_en.
- in_bitmap  in  WIDTH  styled row (styler bitmapOut).
- in_last  in  1  row is the last cell of the current line.
- in_fg, in_bg  in  4 each  colour indices (STYLER_SHIFTER_COLOR_EN only).
- pix_en  in  1  pixel-rate enable; one pixel advances per cycle with pix_en high.
- pix_out  out  1  current pixel; 0 when pix_valid low.
- pix_valid  out  1  active register holds a pixel.
- pix_fg, pix_bg  out  4 each  colours of the current cell; 0 when invalid (COLOR_EN only).
- pix_eol  out  1  high while the current pixel is the final pixel of an in_last cell.
- underrun  out  1  sticky error flag.
- clr_underrun  in  1  clears underrun.

## Operation
- Storage: hold register {bitmap, last, fg, bg, hold_valid} and active register {shift, last, fg, bg, act_valid, cnt}. cnt is log2(WIDTH) bits.
- Accept: when in_valid & in_ready, the hold register captures the inputs and hold_valid sets.
- Transfer (xfer): hold moves to active and cnt becomes 0 when hold_valid & (~act_valid | (pix_en & cnt==WIDTH-1)). xfer clears hold_valid.
- Shift: when act_valid & pix_en & cnt!=WIDTH-1, shift one position toward the output end and increment cnt.
- Last pixel: on pix_en & cnt==WIDTH-1 with no xfer, act_valid clears.
- pix_out is the output-end bit of the shift register, masked by act_valid.
- pix_eol = act_valid & act_last & cnt==WIDTH-1.
- Line tracking: line_active sets on any xfer. It clears when pix_eol & pix_en.
- Underrun: sets when pix_en & line_active & ~act_valid. If set and clr_underrun occur in the same cycle, set wins.
- Between lines (line_active low), pix_en with no data is legal blanking and does not set underrun.

## Timing
- Reset values: in_ready=1, pix_valid=0, pix_out=0, pix_eol=0, underrun=0, pix_fg/pix_bg=0. All registers clear.
- Reset mid-line drops both registers immediately. No partial pixels survive.
- Latency: a row accepted in cycle N reaches hold at the end of N. It loads into active at the end of N+1 if active is empty. The first pixel is visible in cycle N+2.
- Steady state: with pix_en held high and upstream keeping hold full, output is continuous with no gap between cells.
- Full case: hold_valid and act_valid both set drives in_ready=0. in_ready rises the cycle after xfer.
- Simultaneous accept and xfer cannot occur, because in_ready=0 whenever hold_valid=1.

## Configuration
- STYLER_SHIFTER_COLOR_EN defined: in_fg, in_bg, pix_fg and pix_bg exist. Colour registers travel with hold and active.
- STYLER_SHIFTER_COLOR_EN undefined: those ports and registers are absent. The block is monochrome only.

## Structure
- styler_pkg holds the CELL_WIDTH default (16), the colour index width (4), and a packed cell_t {bitmap, last, fg, bg}.
- One sub-module: styler_shifter_hold, the one-entry hold register with handshake. It exposes hold_valid, the cell_t and a pop input.
- The shift register, counter, line and underrun logic live in the top module.

## Test plan
- Single row 16'hA5C3, MSB_FIRST=1, pix_en constant 1 -> pix_out sequence 1010010111000011 starting 2 cycles after accept; pix_valid high for exactly 16 cycles.
- Back-to-back rows 16'hFFFF then 16'h0000 (in_last on the second), pix_en=1 -> 32 contiguous valid pixels; pix_eol high only on pixel 32; line_active then low.
- pix_en toggling every other cycle -> each pixel held for 2 cycles; in_ready low while both registers full; no data lost across 3 rows.
- Upstream stalls after the first cell of a line, pix_en=1 -> underrun sets on the first empty enabled cycle. Same stall after an in_last cell -> underrun stays 0. clr_underrun plus a new underrun in the same cycle -> underrun stays 1.
- rst_n pulsed low mid-cell -> outputs zero asynchronously; after release in_ready=1, pix_valid=0, and the next row shifts out from pixel 0.
- MSB_FIRST=0 with 16'h0001 -> first output pixel 1, remaining 15 pixels 0. With COLOR_EN, pix_fg/pix_bg match in_fg=4'h3/in_bg=4'hC for all 16 pixels.
